dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu_if.sv | 26 ++
 rtl/dmem_lsu.sv | 155 +++++++++++++++
 tb/tb_dmem_lsu.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the CPU memory stage and the load/store unit.
// The master drives requests; the slave (dmem_lsu) accepts them and returns responses.
interface dmem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store data memory: byte/half/word access with extension, programmable wait
// states, and error flagging for misaligned, illegal-size or out-of-range requests.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// WAIT   | counting down wait states; access performed when counter reaches 0
// RESP   | rsp_valid high for one cycle
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input logic       clk,
    input logic       rst,
    dmem_lsu_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic               accept, perform, req_err, oor;
    logic               cap_wr, cap_uns, cap_err;
    logic [1:0]         cap_size, cap_off;
    logic [IDX_W-1:0]   cap_idx;
    logic [31:0]        cap_wdata;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rd_word, ld_data, st_data;
    logic [3:0]         st_be;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    generate
        if (ADDR_W > IDX_W + 2) begin : g_oor
            assign oor = |bus.req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_comb begin
        req_err = oor;
        case (bus.req_size)
            2'b00:   ;
            2'b01:   if (bus.req_addr[0]) req_err = 1'b1;
            2'b10:   if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Errors also pass through WAIT with a zero count so the response lands one edge after accept.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req_valid) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
        accept        = (state == S_IDLE) && bus.req_valid;
        perform       = (state == S_WAIT) && (cnt == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_uns   <= 1'b0;
            cap_err   <= 1'b0;
            cap_size  <= '0;
            cap_off   <= '0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt       <= req_err ? 4'd0 : 4'(WAIT_CYCLES);
            cap_wr    <= bus.req_wr;
            cap_uns   <= bus.req_unsigned;
            cap_err   <= req_err;
            cap_size  <= bus.req_size;
            cap_off   <= bus.req_addr[1:0];
            cap_idx   <= bus.req_addr[IDX_W+1:2];
            cap_wdata <= bus.req_wdata;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign rd_word = mem[cap_idx];

    always_comb begin
        ld_byte = rd_word[{cap_off, 3'b000} +: 8];
        ld_half = cap_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (cap_size)
            2'b00:   ld_data = {{24{~cap_uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~cap_uns & ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        case (cap_size)
            2'b00: begin
                st_data = {4{cap_wdata[7:0]}};
                st_be   = 4'b0001 << cap_off;
            end
            2'b01: begin
                st_data = {2{cap_wdata[15:0]}};
                st_be   = cap_off[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                st_data = cap_wdata;
                st_be   = 4'b1111;
            end
            default: begin
                st_data = '0;
                st_be   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (perform && cap_wr && !cap_err) begin
            for (int i = 0; i < 4; i++)
                if (st_be[i]) mem[cap_idx][i*8 +: 8] <= st_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (perform) begin
            rsp_rdata_q <= (cap_wr || cap_err) ? 32'd0 : ld_data;
            rsp_err_q   <= cap_err;
        end
    end

    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: vector table on a WAIT_CYCLES=1 instance, plus
// back-to-back ready timing on W=0 / W=15 instances and a mid-access reset.
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(32)) b1 ();
    dmem_lsu_if #(.ADDR_W(32)) b0 ();
    dmem_lsu_if #(.ADDR_W(32)) b15 ();

    dmem_lsu #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
    dmem_lsu #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(0))  dut0  (.clk(clk), .rst(rst), .bus(b0));
    dmem_lsu #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(15)) dut15 (.clk(clk), .rst(rst), .bus(b15));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [1:0] s,
                                input logic u, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        v.exp_lat = ee ? 1 : 2;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int k);
        int guard;
        int lat;
        @(negedge clk);
        b1.req_valid    = 1'b1;
        b1.req_wr       = v.wr;
        b1.req_addr     = v.addr;
        b1.req_size     = v.size;
        b1.req_unsigned = v.uns;
        b1.req_wdata    = v.wdata;
        guard = 0;
        while (!b1.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d ready_before_accept", k), {31'b0, b1.req_ready}, 32'd1);
        if (!b1.req_ready) begin
            b1.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        b1.req_wdata = 32'hCAFE_F00D;
        check($sformatf("v%0d busy_after_accept", k), {31'b0, b1.req_ready}, 32'd0);
        lat = 0;
        while (!b1.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", k), lat, v.exp_lat);
        check($sformatf("v%0d rdata", k), b1.rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d err", k), {31'b0, b1.rsp_err}, {31'b0, v.exp_err});
        @(posedge clk);
        #1;
        check($sformatf("v%0d strobe_one_cycle", k), {31'b0, b1.rsp_valid}, 32'd0);
        check($sformatf("v%0d rdata_hold", k), b1.rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d ready_again", k), {31'b0, b1.req_ready}, 32'd1);
    endtask

    task automatic ready_runs(input int sel, input int w);
        int run = 0;
        int nruns = 0;
        int cyc = 0;
        logic r;
        @(negedge clk);
        if (sel == 0) b0.req_valid = 1'b1;
        else          b15.req_valid = 1'b1;
        while (nruns < 3 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            r = (sel == 0) ? b0.req_ready : b15.req_ready;
            if (!r) run++;
            else if (run > 0) begin
                check($sformatf("W%0d ready_low_run%0d", w, nruns), run, w + 2);
                run = 0;
                nruns++;
            end
        end
        b0.req_valid  = 1'b0;
        b15.req_valid = 1'b0;
        check($sformatf("W%0d runs_seen", w), nruns, 3);
    endtask

    initial begin
        vec_t vt[$];
        vec_t vr[$];

        vt.push_back(mk(1, 32'h010, 2'd2, 0, 32'hDEADBEEF, 32'h0,        0));
        vt.push_back(mk(0, 32'h010, 2'd2, 0, 32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk(1, 32'h011, 2'd0, 0, 32'h00000055, 32'h0,        0));
        vt.push_back(mk(0, 32'h010, 2'd2, 0, 32'h0,        32'hDEAD55EF, 0));
        vt.push_back(mk(0, 32'h013, 2'd0, 0, 32'h0,        32'hFFFFFFDE, 0));
        vt.push_back(mk(0, 32'h013, 2'd0, 1, 32'h0,        32'h000000DE, 0));
        vt.push_back(mk(0, 32'h010, 2'd0, 0, 32'h0,        32'hFFFFFFEF, 0));
        vt.push_back(mk(0, 32'h011, 2'd0, 1, 32'h0,        32'h00000055, 0));
        vt.push_back(mk(0, 32'h010, 2'd1, 0, 32'h0,        32'h000055EF, 0));
        vt.push_back(mk(0, 32'h012, 2'd1, 0, 32'h0,        32'hFFFFDEAD, 0));
        vt.push_back(mk(1, 32'h022, 2'd1, 0, 32'hFFFF8001, 32'h0,        0));
        vt.push_back(mk(0, 32'h022, 2'd1, 0, 32'h0,        32'hFFFF8001, 0));
        vt.push_back(mk(0, 32'h022, 2'd1, 1, 32'h0,        32'h00008001, 0));
        vt.push_back(mk(0, 32'h020, 2'd2, 0, 32'h0,        32'h80010000, 0));
        vt.push_back(mk(0, 32'h012, 2'd2, 0, 32'h0,        32'h0,        1));
        vt.push_back(mk(1, 32'h021, 2'd1, 0, 32'h00001234, 32'h0,        1));
        vt.push_back(mk(0, 32'h020, 2'd3, 0, 32'h0,        32'h0,        1));
        vt.push_back(mk(0, 32'h400, 2'd2, 0, 32'h0,        32'h0,        1));
        vt.push_back(mk(1, 32'h400, 2'd2, 0, 32'hFFFFFFFF, 32'h0,        1));
        vt.push_back(mk(1, 32'h023, 2'd3, 0, 32'h00000099, 32'h0,        1));
        vt.push_back(mk(0, 32'h020, 2'd2, 0, 32'h0,        32'h80010000, 0));
        vt.push_back(mk(1, 32'h023, 2'd0, 0, 32'hAABBCC7F, 32'h0,        0));
        vt.push_back(mk(0, 32'h020, 2'd2, 0, 32'h0,        32'h7F010000, 0));
        vt.push_back(mk(0, 32'h023, 2'd0, 0, 32'h0,        32'h0000007F, 0));
        vt.push_back(mk(1, 32'h3FC, 2'd2, 0, 32'hA5A50001, 32'h0,        0));
        vt.push_back(mk(0, 32'h3FC, 2'd2, 1, 32'h0,        32'hA5A50001, 0));
        vt.push_back(mk(0, 32'h3FE, 2'd1, 1, 32'h0,        32'h0000A5A5, 0));
        vt.push_back(mk(0, 32'h3FC, 2'd0, 0, 32'h0,        32'h00000001, 0));
        vt.push_back(mk(1, 32'h3FF, 2'd1, 0, 32'h0000FFFF, 32'h0,        1));

        vr.push_back(mk(0, 32'h000, 2'd2, 0, 32'h0,        32'h0,        0));
        vr.push_back(mk(0, 32'h010, 2'd2, 0, 32'h0,        32'h0,        0));

        b1.req_valid = 0; b1.req_wr = 0; b1.req_addr = 0; b1.req_size = 0;
        b1.req_unsigned = 0; b1.req_wdata = 0;
        b0.req_valid = 0; b0.req_wr = 0; b0.req_addr = 0; b0.req_size = 2'd2;
        b0.req_unsigned = 0; b0.req_wdata = 0;
        b15.req_valid = 0; b15.req_wr = 0; b15.req_addr = 32'h4; b15.req_size = 2'd2;
        b15.req_unsigned = 0; b15.req_wdata = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", {31'b0, b1.req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, b1.rsp_valid}, 32'd0);
        check("reset rsp_rdata", b1.rsp_rdata, 32'd0);
        check("reset rsp_err",   {31'b0, b1.rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

        ready_runs(0, 0);
        ready_runs(1, 15);

        // Reset lands while the store is still counting down its wait state.
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_wr = 1'b1; b1.req_addr = 32'h0;
        b1.req_size = 2'd2; b1.req_unsigned = 1'b0; b1.req_wdata = 32'h12345678;
        check("rst_seq ready_before_accept", {31'b0, b1.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        check("rst_seq busy", {31'b0, b1.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_seq ready_immediate", {31'b0, b1.req_ready}, 32'd1);
        check("rst_seq no_rsp", {31'b0, b1.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_seq quiet%0d", c), {31'b0, b1.rsp_valid}, 32'd0);
        end
        for (int i = 0; i < vr.size(); i++) run_vec(vr[i], 100 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
